// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity rule and stop-bit lengths.
// The receive path uses parity_bit() as well, so both ends agree on the parity rule.
package uart_pkg;

    typedef enum logic [2:0] {idle, start, send, parity, stop} tx_state_t;

    // Stop length expressed in half-bit units: 1, 1.5 and 2 stop bits.
    localparam int STOP_HALVES_1   = 2;
    localparam int STOP_HALVES_1P5 = 3;
    localparam int STOP_HALVES_2   = 4;

    function automatic int stop_len(input int os, input logic [1:0] wls, input logic stb);
        if (!stb)
            return os * STOP_HALVES_1 / 2;
        if (wls == 2'b00)
            return os * STOP_HALVES_1P5 / 2;
        return os * STOP_HALVES_2 / 2;
    endfunction

    // {sticky,eps}: 00 odd, 01 even, 10 forced 1, 11 forced 0.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                        input logic eps, input logic sticky);
        logic [7:0] masked;
        masked = data & (8'hFF >> (2'd3 - wls));
        case ({sticky, eps})
            2'b00:   return ~(^masked);
            2'b01:   return ^masked;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_top.sv
// 16550-style serial transmitter: pulls bytes from the TX FIFO and emits
// start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       fifo_empty,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic       set_break,
    output logic       pop,
    output logic       sreg_empty,
    output logic       tx
);

    localparam int CW = $clog2(2 * OVERSAMPLE);
    localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stop_cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    sreg;
    logic [1:0]    wls_q;
    logic          stb_q;
    logic          pen_q;
    logic          par_q;
    logic          line;
    logic          cnt_done;
    logic          load;

    assign cnt_done = (cnt == '0);
    assign stop_cnt = CW'(stop_len(OVERSAMPLE, wls_q, stb_q) - 1);
    // The end of a stop bit doubles as a load slot so back-to-back frames have no idle gap.
    assign load = baud_pulse && !fifo_empty && (state == idle || (state == stop && cnt_done));

    // line is the FSM's bit level; tx is that level with break applied, updated every clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= idle;
            cnt        <= '0;
            bitcnt     <= '0;
            sreg       <= '0;
            wls_q      <= '0;
            stb_q      <= 1'b0;
            pen_q      <= 1'b0;
            par_q      <= 1'b0;
            line       <= 1'b1;
            tx         <= 1'b1;
            pop        <= 1'b0;
            sreg_empty <= 1'b1;
        end else begin
            pop <= 1'b0;
            tx  <= line & ~set_break;
            if (load) begin
                sreg       <= din;
                wls_q      <= wls;
                stb_q      <= stb;
                pen_q      <= pen;
                par_q      <= parity_bit(din, wls, eps, sticky_parity);
                pop        <= 1'b1;
                sreg_empty <= 1'b0;
                line       <= 1'b0;
                tx         <= 1'b0;
                cnt        <= BIT_LAST;
                state      <= start;
            end else if (baud_pulse && state != idle) begin
                if (!cnt_done) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    case (state)
                        start: begin
                            line   <= sreg[0];
                            tx     <= sreg[0] & ~set_break;
                            sreg   <= sreg >> 1;
                            bitcnt <= 3'd4 + {1'b0, wls_q};
                            cnt    <= BIT_LAST;
                            state  <= send;
                        end
                        send: begin
                            if (bitcnt != 3'd0) begin
                                line   <= sreg[0];
                                tx     <= sreg[0] & ~set_break;
                                sreg   <= sreg >> 1;
                                bitcnt <= bitcnt - 1'b1;
                                cnt    <= BIT_LAST;
                            end else if (pen_q) begin
                                line  <= par_q;
                                tx    <= par_q & ~set_break;
                                cnt   <= BIT_LAST;
                                state <= parity;
                            end else begin
                                line  <= 1'b1;
                                tx    <= ~set_break;
                                cnt   <= stop_cnt;
                                state <= stop;
                            end
                        end
                        parity: begin
                            line  <= 1'b1;
                            tx    <= ~set_break;
                            cnt   <= stop_cnt;
                            state <= stop;
                        end
                        stop: begin
                            sreg_empty <= 1'b1;
                            state      <= idle;
                        end
                        default: state <= idle;
                    endcase
                end
            end
        end
    end

endmodule
